dmem_responder: RTL and testbench

Memory-side responder for the processor's data-memory port: accepts one load/store request at a time over a valid/ready handshake, inserts a programmable number of wait states, then performs the access and returns a single-cycle response. It sits between the core's load/store path and the data RAM. It replaces the zero-latency combinational data memory when slower memory timing or error reporting is needed.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 45 ++++
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and widths for the data-memory responder.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int WAIT_W = 4;

  // Responder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : DEPTH x 32 register array, synchronous byte-enabled write port
//            and a registered read port. Contents are not reset.
// Revision : 1.0
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-granular store: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register captures the addressed word only when a load is performed.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Memory-side responder for the data port. Accepts one request at
//            a time, waits WAIT_CYCLES, performs the access and returns a
//            single-cycle response with error reporting.
// Revision : 1.0
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic                busy
);

  localparam int                IDX_W       = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] CNT_INIT    = (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W - 2)'(DEPTH);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic                rsp_error_q;
  logic                rsp_zero_q;

  logic                enter_resp;
  logic                acc_write;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [DATA_W/8-1:0] acc_be;
  logic                addr_err;
  logic                mem_we;
  logic                mem_re;
  logic [DATA_W-1:0]   mem_rdata;

  // State, counter and request latch registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Next-state logic: accept in IDLE, count wait states, single RESP cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access happens on the RESP-entry edge. With zero wait states that
  // edge is the acceptance edge, so the live request is used instead of the
  // latch, which has not been loaded yet.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  // Misaligned or beyond-the-array word index is rejected; no wrap-around.
  assign addr_err = (acc_addr[1:0] != 2'b00) || (acc_addr[ADDR_W-1:2] >= DEPTH_WORDS);
  assign mem_we   = enter_resp &&  acc_write && !addr_err;
  assign mem_re   = enter_resp && !acc_write && !addr_err;

  // Response qualifiers captured alongside the access; zero flag masks data
  // for stores, errors and the post-reset state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_error_q <= 1'b0;
      rsp_zero_q  <= 1'b1;
    end else if (enter_resp) begin
      rsp_error_q <= addr_err;
      rsp_zero_q  <= acc_write || addr_err;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .idx_i   (acc_addr[IDX_W+1:2]),
    .be_i    (acc_be),
    .wdata_i (acc_wdata),
    .rdata_o (mem_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_zero_q ? '0 : mem_rdata;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder. One instance
//            uses WAIT_CYCLES = 2, a second uses WAIT_CYCLES = 0; a select
//            line routes the shared request bus to one of them.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;

  logic        ready2, rv2, err2, busy2;
  logic [31:0] rd2;
  logic        ready0, rv0, err0, busy0;
  logic [31:0] rd0;

  logic        m_ready, m_rv, m_err, m_busy;
  logic [31:0] m_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid && !sel),
    .req_ready (ready2),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rv2),
    .rsp_rdata (rd2),
    .rsp_error (err2),
    .busy      (busy2)
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid && sel),
    .req_ready (ready0),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rv0),
    .rsp_rdata (rd0),
    .rsp_error (err0),
    .busy      (busy0)
  );

  assign m_ready = sel ? ready0 : ready2;
  assign m_rv    = sel ? rv0    : rv2;
  assign m_err   = sel ? err0   : err2;
  assign m_busy  = sel ? busy0  : busy2;
  assign m_rd    = sel ? rd0    : rd2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; returns data, error and the number of cycles
  // from the handshake cycle to the rsp_valid cycle.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    int k;
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    k = 0;
    while (!m_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", 32'(m_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("ready_low_busy", 32'(m_ready), 32'd0);
    check("busy_high", 32'(m_busy), 32'd1);
    lat = 1;
    while (!m_rv && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = m_rd;
    err   = m_err;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(m_ready), 32'd1);
    check({tag, "_rv"},    32'(m_rv),    32'd0);
    check({tag, "_rdata"}, m_rd,         32'd0);
    check({tag, "_err"},   32'(m_err),   32'd0);
    check({tag, "_busy"},  32'(m_busy),  32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int acc, pulses, last, spacing_bad, ready_bad, data_bad, rv_seen;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Store then load, with latency
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("st10_lat", 32'(lat), 32'd3);
    check("st10_err", 32'(er), 32'd0);
    check("st10_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld10_lat", 32'(lat), 32'd3);
    check("ld10_err", 32'(er), 32'd0);
    check("ld10_rdata", rd, 32'hDEADBEEF);

    // Partial byte-enable store
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check("ld20_merge", rd, 32'h11BB33DD);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("ld20_be0", rd, 32'h11BB33DD);

    // Error cases and boundaries
    do_req(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rdata", rd, 32'd0);
    do_req(1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
    check("oob_err", 32'(er), 32'd1);
    check("oob_rdata", rd, 32'd0);
    do_req(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, rd, er, lat);
    check("top_err", 32'(er), 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld10_after_err", rd, 32'hDEADBEEF);
    check("ld10_after_err_e", 32'(er), 32'd0);
    do_req(1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF, rd, er, lat);
    check("st3fc_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    check("ld3fc", rd, 32'h0BADCAFE);
    do_req(1'b1, 32'h0, 32'h55555555, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("st400_err", 32'(er), 32'd1);
    do_req(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("st2_err", 32'(er), 32'd1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("ld0_nowrap", rd, 32'h55555555);

    // Back-to-back loads with req_valid held
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 32'h10;
    req_valid = 1'b1;
    acc = 0; pulses = 0; last = -1; spacing_bad = 0; ready_bad = 0; data_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (acc == 4) req_valid = 1'b0;
      if (m_rv) begin
        if (pulses > 0 && (c - last) != 4) spacing_bad++;
        if (m_rd !== 32'hDEADBEEF) data_bad++;
        last = c;
        pulses++;
      end
      if (m_busy && m_ready) ready_bad++;
      if (req_valid && m_ready) acc++;
      @(negedge clk);
    end
    check("b2b_accepts", 32'(acc), 32'd4);
    check("b2b_pulses", 32'(pulses), 32'd4);
    check("b2b_spacing", 32'(spacing_bad), 32'd0);
    check("b2b_ready", 32'(ready_bad), 32'd0);
    check("b2b_data", 32'(data_bad), 32'd0);

    // Reset during WAIT aborts a store
    do_req(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, rd, er, lat);
    do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    check("ld30_pre", rd, 32'hCAFEF00D);
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    req_valid = 1'b1;
    check("abort_ready", 32'(m_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_wait", 32'(m_busy), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    rv_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (m_rv) rv_seen++;
    end
    check_reset_outputs("abort_hold");
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_rv) rv_seen++;
    end
    check("abort_no_rsp", 32'(rv_seen), 32'd0);
    do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    check("ld30_old", rd, 32'hCAFEF00D);

    // Zero wait states instance
    @(negedge clk);
    sel = 1'b1;
    do_req(1'b1, 32'h40, 32'hA5A50F0F, 4'hF, rd, er, lat);
    check("w0_st_lat", 32'(lat), 32'd1);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    check("w0_ld_lat", 32'(lat), 32'd1);
    check("w0_ld_rdata", rd, 32'hA5A50F0F);
    check("w0_ld_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
    check("w0_oob_err", 32'(er), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dmem_responder
`default_nettype wire
